// File: rtl/game_display_ctrl.sv
// game_display_ctrl: registered seven-segment / LED driver for the number-guessing game.
// Define GAME_DISP_SCROLL_EN to rotate the win/lose message across the digits.
module game_display_ctrl #(
  parameter int unsigned TIMER_W      = 8,
  parameter int unsigned TIMER_DIGITS = 2,
  parameter int unsigned NUM_GUESS    = 3,
  parameter int unsigned LOW_THRESH   = 10,
  parameter int unsigned BLINK_DIV    = 12_500_000,
  parameter int unsigned SCROLL_DIV   = 25_000_000
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [TIMER_W-1:0]                        timer,
  input  logic [2:0]                                guesses,
  input  logic [1:0]                                hint,
  input  logic [4*NUM_GUESS-1:0]                    guess_vec,
  input  logic [1:0]                                win_lose,
  input  logic [1:0]                                round,
  input  logic [1:0]                                difficulty,
  output logic [7*(TIMER_DIGITS+3+NUM_GUESS)-1:0]   seg,
  output logic [2:0]                                round_led,
  output logic [2:0]                                diff_led,
  output logic                                      busy
);

  localparam int unsigned NUM_DIGITS = TIMER_DIGITS + 3 + NUM_GUESS;
  localparam int unsigned BCD_RAW    = (TIMER_W * 3) / 10 + 1;
  localparam int unsigned BCD_D      = (BCD_RAW > TIMER_DIGITS) ? BCD_RAW : TIMER_DIGITS;
  localparam int unsigned SR_W       = 4 * BCD_D + TIMER_W;
  localparam int unsigned CNT_W      = $clog2(TIMER_W + 1);
  localparam int unsigned BLK_W      = $clog2(BLINK_DIV);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] TIMER_LIMIT = pow10(TIMER_DIGITS);

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = BLANK;
    endcase
    return g;
  endfunction

  // Nine-character message ring: "good job " for a win, "You Lose " otherwise.
  function automatic logic [6:0] msg_glyph(input logic win, input logic [3:0] idx);
    logic [6:0] g;
    g = BLANK;
    if (win) begin
      case (idx)
        4'd0:    g = 7'b0010000;
        4'd1:    g = 7'b0100011;
        4'd2:    g = 7'b0100011;
        4'd3:    g = 7'b0100001;
        4'd5:    g = 7'b1110001;
        4'd6:    g = 7'b0100011;
        4'd7:    g = 7'b0000011;
        default: g = BLANK;
      endcase
    end else begin
      case (idx)
        4'd0:    g = 7'b0010001;
        4'd1:    g = 7'b0100011;
        4'd2:    g = 7'b1100011;
        4'd4:    g = 7'b1000111;
        4'd5:    g = 7'b0100011;
        4'd6:    g = 7'b0010010;
        4'd7:    g = 7'b0000100;
        default: g = BLANK;
      endcase
    end
    return g;
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] v);
    logic [2:0] r;
    case (v)
      2'd1:    r = 3'b001;
      2'd2:    r = 3'b010;
      2'd3:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic                      load_c, shift_c, done_c;
  logic [TIMER_W-1:0]        t_q;
  logic [SR_W-1:0]           sr, sr_adj, sr_shift;
  logic [CNT_W-1:0]          bit_cnt;
  logic [4*TIMER_DIGITS-1:0] bcd_q;
  logic                      conv_valid;
  logic [BLK_W-1:0]          blink_cnt;
  logic                      blink_ph;
  logic                      msg_c, win_c;
  logic [7*NUM_DIGITS-1:0]   seg_nxt;

  assign msg_c = ~win_lose[1];
  assign win_c = (win_lose == 2'd1);

  // BCD conversion FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!conv_valid || (timer != t_q)) state_nxt = S_SHIFT;
      S_SHIFT: if (bit_cnt == CNT_W'(TIMER_W - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    case (state)
      S_IDLE:  load_c  = (state_nxt == S_SHIFT);
      S_SHIFT: shift_c = 1'b1;
      S_DONE:  done_c  = 1'b1;
      default: ;
    endcase
  end

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < int'(BCD_D); k++) begin
      if (sr[TIMER_W + 4*k +: 4] >= 4'd5)
        sr_adj[TIMER_W + 4*k +: 4] = sr[TIMER_W + 4*k +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q        <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      bcd_q      <= '0;
      conv_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      if (load_c) begin
        t_q     <= timer;
        sr      <= SR_W'(timer);
        bit_cnt <= '0;
      end else if (shift_c) begin
        sr      <= sr_shift;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (done_c) begin
        bcd_q      <= sr[TIMER_W +: 4*TIMER_DIGITS];
        conv_valid <= 1'b1;
      end
    end
  end

  // Free-running low-time blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

`ifdef GAME_DISP_SCROLL_EN
  localparam int unsigned SCR_W = $clog2(SCROLL_DIV);

  logic [SCR_W-1:0] scr_cnt;
  logic [3:0]       offset, offset_nxt;
  logic             prev_msg, prev_win, restart_c;

  // A fresh message (or a win/lose swap) always starts from its first character.
  assign restart_c = msg_c && (!prev_msg || (prev_win != win_c));

  always_comb begin
    offset_nxt = offset;
    if (restart_c)
      offset_nxt = 4'd0;
    else if (msg_c && (scr_cnt == SCR_W'(SCROLL_DIV - 1)))
      offset_nxt = (offset == 4'd8) ? 4'd0 : offset + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scr_cnt  <= '0;
      offset   <= '0;
      prev_msg <= 1'b0;
      prev_win <= 1'b0;
    end else begin
      prev_msg <= msg_c;
      prev_win <= win_c;
      offset   <= offset_nxt;
      if (restart_c)
        scr_cnt <= '0;
      else if (msg_c)
        scr_cnt <= (scr_cnt == SCR_W'(SCROLL_DIV - 1)) ? '0 : scr_cnt + SCR_W'(1);
    end
  end
`endif

  // Next display image; timer digits use state from before this edge.
  always_comb begin
    logic [3:0] d;
    logic       lead;
    logic       over;
    logic       hide;
    seg_nxt = {NUM_DIGITS{BLANK}};
    d       = 4'd0;
    lead    = 1'b1;
    over    = (64'(t_q) >= TIMER_LIMIT);
    hide    = blink_ph && (64'(t_q) <= 64'(LOW_THRESH));
    if (msg_c) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
`ifdef GAME_DISP_SCROLL_EN
        seg_nxt[7*i +: 7] = msg_glyph(win_c, 4'((int'(offset_nxt) + i) % 9));
`else
        if (i < 8) seg_nxt[7*i +: 7] = msg_glyph(win_c, 4'(i));
`endif
      end
    end else begin
      for (int j = 0; j < int'(TIMER_DIGITS); j++) begin
        d = bcd_q[4*(int'(TIMER_DIGITS) - 1 - j) +: 4];
        if (!conv_valid || hide) begin
          seg_nxt[7*j +: 7] = BLANK;
        end else if (over) begin
          seg_nxt[7*j +: 7] = DASH;
        end else if (lead && (d == 4'd0) && (j < int'(TIMER_DIGITS) - 1)) begin
          seg_nxt[7*j +: 7] = BLANK;
        end else begin
          lead              = 1'b0;
          seg_nxt[7*j +: 7] = digit_glyph(d);
        end
      end
      if ((guesses >= 3'd1) && (guesses <= 3'd5))
        seg_nxt[7*TIMER_DIGITS +: 7] = digit_glyph({1'b0, guesses});
      case ({hint})
        2'd0:    seg_nxt[7*(TIMER_DIGITS+1) +: 7] = 7'b1000111;
        2'd1:    seg_nxt[7*(TIMER_DIGITS+1) +: 7] = 7'b0001001;
        default: seg_nxt[7*(TIMER_DIGITS+1) +: 7] = 7'b1110111;
      endcase
      for (int g = 0; g < int'(NUM_GUESS); g++)
        seg_nxt[7*(int'(TIMER_DIGITS) + 3 + g) +: 7] = digit_glyph(guess_vec[4*g +: 4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg       <= '1;
      round_led <= 3'b000;
      diff_led  <= 3'b000;
    end else begin
      seg       <= seg_nxt;
      round_led <= one_hot(round);
      diff_led  <= one_hot(difficulty);
    end
  end

endmodule
